// File: rtl/bus_xcvr_ctrl.sv
// rtl/bus_xcvr_ctrl.sv - control-pin sequencer for a 74646/74648-class registered bus transceiver
// Runs DIR turnaround, optional source capture and the output-enable window for one-word transfers.
module bus_xcvr_ctrl #(
  parameter int DRIVE_CYCLES = 2,
  parameter int TURN_CYCLES  = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,
  input  logic req_dir_i,
  input  logic req_stored_i,
  input  logic abort_i,
  output logic busy_o,
  output logic done_o,
  output logic xcvr_dir_o,
  output logic xcvr_oe_n_o,
  output logic xcvr_clkab_o,
  output logic xcvr_clkba_o,
  output logic xcvr_sab_o,
  output logic xcvr_sba_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN    = 3'd1,
    SETUP   = 3'd2,
    CAPTURE = 3'd3,
    DRIVE   = 3'd4
  } state_e;

  localparam logic [2:0] TURN_LAST  = 3'(TURN_CYCLES - 1);
  localparam logic [3:0] DRIVE_LAST = 4'(DRIVE_CYCLES - 1);

  state_e     state_q;
  logic [2:0] turn_cnt_q;
  logic [3:0] drive_cnt_q;
  logic       stored_q;
  logic       busy_q;
  logic       done_q;
  logic       dir_q;
  logic       oe_n_q;
  logic       clkab_q;
  logic       clkba_q;
  logic       sab_q;
  logic       sba_q;

  // Every output is a flop: values are chosen for the state being entered, so the
  // selects settle in SETUP one cycle before OE_n can fall in DRIVE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      turn_cnt_q  <= 3'd0;
      drive_cnt_q <= 4'd0;
      stored_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dir_q       <= 1'b0;
      oe_n_q      <= 1'b1;
      clkab_q     <= 1'b0;
      clkba_q     <= 1'b0;
      sab_q       <= 1'b0;
      sba_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      clkab_q <= 1'b0;
      clkba_q <= 1'b0;
      if (abort_i && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        oe_n_q  <= 1'b1;
        sab_q   <= 1'b0;
        sba_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            oe_n_q <= 1'b1;
            sab_q  <= 1'b0;
            sba_q  <= 1'b0;
            if (req_i) begin
              stored_q <= req_stored_i;
              busy_q   <= 1'b1;
              if (req_dir_i != dir_q) begin
                state_q    <= TURN;
                dir_q      <= req_dir_i;
                turn_cnt_q <= TURN_LAST;
              end else begin
                state_q <= SETUP;
                sab_q   <= req_dir_i & req_stored_i;
                sba_q   <= ~req_dir_i & req_stored_i;
              end
            end
          end
          TURN: begin
            oe_n_q <= 1'b1;
            if (turn_cnt_q == 3'd0) begin
              state_q <= SETUP;
              sab_q   <= dir_q & stored_q;
              sba_q   <= ~dir_q & stored_q;
            end else begin
              turn_cnt_q <= turn_cnt_q - 3'd1;
            end
          end
          SETUP: begin
            if (stored_q) begin
              state_q <= CAPTURE;
              oe_n_q  <= 1'b1;
              clkab_q <= dir_q;
              clkba_q <= ~dir_q;
            end else begin
              state_q     <= DRIVE;
              oe_n_q      <= 1'b0;
              drive_cnt_q <= DRIVE_LAST;
            end
          end
          CAPTURE: begin
            state_q     <= DRIVE;
            oe_n_q      <= 1'b0;
            drive_cnt_q <= DRIVE_LAST;
          end
          DRIVE: begin
            if (drive_cnt_q == 4'd0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              oe_n_q  <= 1'b1;
              sab_q   <= 1'b0;
              sba_q   <= 1'b0;
            end else begin
              drive_cnt_q <= drive_cnt_q - 4'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            oe_n_q  <= 1'b1;
            sab_q   <= 1'b0;
            sba_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign xcvr_dir_o   = dir_q;
  assign xcvr_oe_n_o  = oe_n_q;
  assign xcvr_clkab_o = clkab_q;
  assign xcvr_clkba_o = clkba_q;
  assign xcvr_sab_o   = sab_q;
  assign xcvr_sba_o   = sba_q;

endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// tb/tb_bus_xcvr_ctrl.sv - scoreboard bench for bus_xcvr_ctrl
// Expected vectors are {busy, done, dir, oe_n, clkab, clkba, sab, sba}.
module tb_bus_xcvr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req_a, dir_a, sto_a, abort_a;
  logic busy_a, done_a, xdir_a, oe_n_a, clkab_a, clkba_a, sab_a, sba_a;
  logic req_b, dir_b, sto_b, abort_b;
  logic busy_b, done_b, xdir_b, oe_n_b, clkab_b, clkba_b, sab_b, sba_b;

  bus_xcvr_ctrl dut_a (
    .clk_i(clk), .reset_i(rst), .req_i(req_a), .req_dir_i(dir_a),
    .req_stored_i(sto_a), .abort_i(abort_a), .busy_o(busy_a), .done_o(done_a),
    .xcvr_dir_o(xdir_a), .xcvr_oe_n_o(oe_n_a), .xcvr_clkab_o(clkab_a),
    .xcvr_clkba_o(clkba_a), .xcvr_sab_o(sab_a), .xcvr_sba_o(sba_a)
  );

  bus_xcvr_ctrl #(.DRIVE_CYCLES(15), .TURN_CYCLES(7)) dut_b (
    .clk_i(clk), .reset_i(rst), .req_i(req_b), .req_dir_i(dir_b),
    .req_stored_i(sto_b), .abort_i(abort_b), .busy_o(busy_b), .done_o(done_b),
    .xcvr_dir_o(xdir_b), .xcvr_oe_n_o(oe_n_b), .xcvr_clkab_o(clkab_b),
    .xcvr_clkba_o(clkba_b), .xcvr_sab_o(sab_b), .xcvr_sba_o(sba_b)
  );

  localparam logic [7:0] RESET_VEC = 8'b0001_0000;

  logic [7:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  function automatic logic [7:0] vec_a();
    return {busy_a, done_a, xdir_a, oe_n_a, clkab_a, clkba_a, sab_a, sba_a};
  endfunction

  function automatic logic [7:0] vec_b();
    return {busy_b, done_b, xdir_b, oe_n_b, clkab_b, clkba_b, sab_b, sba_b};
  endfunction

  // Cycle k = the cycle after the k-th edge, counting the REQ-sampling edge as edge 0.
  task automatic push_xfer(input bit dir, input bit stored, input bit change,
                           input int dcyc, input int tcyc, input int upto, input bit tail);
    int t;
    int s;
    int last;
    bit sab;
    bit sba;
    logic [7:0] v;
    t    = change ? tcyc : 0;
    s    = t + 2 + (stored ? 1 : 0);
    last = s + dcyc;
    sab  = dir & stored;
    sba  = ~dir & stored;
    for (int k = 1; k <= last + (tail ? 1 : 0); k++) begin
      if (upto != 0 && k > upto) break;
      if (k <= t)                      v = {1'b1, 1'b0, dir, 1'b1, 4'b0000};
      else if (k == t + 1)             v = {1'b1, 1'b0, dir, 1'b1, 2'b00, sab, sba};
      else if (stored && k == t + 2)   v = {1'b1, 1'b0, dir, 1'b1, dir, ~dir, sab, sba};
      else if (k < last)               v = {1'b1, 1'b0, dir, 1'b0, 2'b00, sab, sba};
      else if (k == last)              v = {1'b0, 1'b1, dir, 1'b1, 4'b0000};
      else                             v = {1'b0, 1'b0, dir, 1'b1, 4'b0000};
      exp_q.push_back(v);
    end
  endtask

  task automatic tick(input bit sel, output logic [7:0] got, output logic [7:0] exp,
                      output bit have);
    @(posedge clk);
    #1;
    got  = sel ? vec_b() : vec_a();
    have = (exp_q.size() != 0);
    exp  = have ? exp_q.pop_front() : 8'hxx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if (vec_a() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_a: got %b want %b", vec_a(), RESET_VEC);
    end
    vectors++;
    if (vec_b() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_b: got %b want %b", vec_b(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (vec_a() !== RESET_VEC) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", vec_a(), RESET_VEC);
    end
  endtask

  task automatic test_stored_ba();
    logic [7:0] got, exp;
    bit have;
    int n;
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b0; sto_a = 1'b1;
    push_xfer(1'b0, 1'b1, 1'b0, 2, 1, 0, 1'b1);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) req_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL stored_ba cycle %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_turn_realtime();
    logic [7:0] got, exp;
    bit have;
    int n;
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b1; sto_a = 1'b0;
    push_xfer(1'b1, 1'b0, 1'b1, 2, 1, 0, 1'b1);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) req_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL turn_realtime cycle %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    bit have;
    int n;
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b1; sto_a = 1'b1;
    push_xfer(1'b1, 1'b1, 1'b0, 2, 1, 0, 1'b0);
    push_xfer(1'b1, 1'b1, 1'b0, 2, 1, 0, 1'b0);
    push_xfer(1'b1, 1'b1, 1'b0, 2, 1, 0, 1'b1);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 11) req_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_abort_drive();
    logic [7:0] got, exp;
    bit have;
    int n;
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b1; sto_a = 1'b1;
    push_xfer(1'b1, 1'b1, 1'b0, 2, 1, 3, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) req_a = 1'b0;
      if (i == 3) abort_a = 1'b1;
      if (i == 4) abort_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL abort_drive cycle %0d: got %b want %b", i, got, exp);
      end
    end
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b0; sto_a = 1'b0;
    push_xfer(1'b0, 1'b0, 1'b1, 2, 1, 0, 1'b1);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) req_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL after_abort cycle %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_abort_turn();
    logic [7:0] got, exp;
    bit have;
    int n;
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b1; sto_a = 1'b1;
    push_xfer(1'b1, 1'b1, 1'b1, 2, 1, 1, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) begin
        req_a   = 1'b0;
        abort_a = 1'b1;
      end
      if (i == 2) abort_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL abort_turn cycle %0d: got %b want %b", i, got, exp);
      end
    end
    @(negedge clk);
    req_a = 1'b1; abort_a = 1'b1; dir_a = 1'b1; sto_a = 1'b0;
    push_xfer(1'b1, 1'b0, 1'b0, 2, 1, 0, 1'b1);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) begin
        req_a   = 1'b0;
        abort_a = 1'b0;
      end
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL abort_with_req cycle %0d: got %b want %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_capture();
    logic [7:0] got, exp;
    bit have;
    @(negedge clk);
    req_a = 1'b1; dir_a = 1'b1; sto_a = 1'b1;
    push_xfer(1'b1, 1'b1, 1'b0, 2, 1, 2, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      tick(1'b0, got, exp, have);
      if (i == 1) req_a = 1'b0;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL reset_capture cycle %0d: got %b want %b", i, got, exp);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (vec_a() !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset_in_capture: got %b want %b", vec_a(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_long_params();
    logic [7:0] got, exp;
    bit have;
    int n;
    int done_at;
    done_at = -1;
    @(negedge clk);
    req_b = 1'b1; dir_b = 1'b1; sto_b = 1'b1;
    push_xfer(1'b1, 1'b1, 1'b1, 15, 7, 0, 1'b1);
    n = exp_q.size();
    for (int i = 1; i <= n; i++) begin
      tick(1'b1, got, exp, have);
      if (i == 1) req_b = 1'b0;
      if (got[6] === 1'b1 && done_at < 0) done_at = i;
      vectors++;
      if (!have || got !== exp) begin
        errors++;
        $display("FAIL long_params cycle %0d: got %b want %b", i, got, exp);
      end
    end
    vectors++;
    if (done_at !== 25) begin
      errors++;
      $display("FAIL long_done_cycle: got %0d want 25", done_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; dir_a = 1'b0; sto_a = 1'b0; abort_a = 1'b0;
    req_b = 1'b0; dir_b = 1'b0; sto_b = 1'b0; abort_b = 1'b0;
    test_reset();
    test_stored_ba();
    test_turn_realtime();
    test_back_to_back();
    test_abort_drive();
    test_abort_turn();
    test_reset_capture();
    test_long_params();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bus_xcvr_ctrl.md
# bus_xcvr_ctrl

Sequencer that drives the control pins of one octal registered bus transceiver (74646/74648 class) between two buses, A and B. It accepts one-word transfer requests over a req/busy/done handshake. For each request it runs DIR turnaround, source capture, and the output-enable window with correct ordering. It never enables the transceiver outputs while DIR or the select lines are changing. It sits between the bus-cycle logic and the transceiver instance on the datapath.

## Interface
- DRIVE_CYCLES, default 2: cycles the transceiver outputs stay enabled per transfer; legal 1..15.
- TURN_CYCLES, default 1: dead cycles with outputs disabled after a DIR change; legal 1..7.

- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  1  transfer request; sampled only in IDLE.
- REQ_DIR  input  1  1 = A to B, 0 = B to A; sampled with REQ.
- REQ_STORED  input  1  1 = capture the source into the internal register and drive from it; 0 = real-time pass-through.
- ABORT  input  1  synchronous abort of the current transfer.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse when a transfer completes normally.
- XCVR_DIR  output  1  transceiver DIR.
- XCVR_OE_n  output  1  transceiver output enable; low enables the outputs.
- XCVR_CLKAB  output  1  capture strobe for the A-side register.
- XCVR_CLKBA  output  1  capture strobe for the B-side register.
- XCVR_SAB  output  1  A to B select; 1 = stored, 0 = real-time.
- XCVR_SBA  output  1  B to A select; 1 = stored, 0 = real-time.

## Operation
- States: IDLE, TURN, SETUP, CAPTURE, DRIVE. All outputs are registered.
- Reset values (applied asynchronously):
  - State IDLE.
  - XCVR_OE_n = 1.
  - XCVR_DIR = 0, and the last-direction register = 0.
  - XCVR_CLKAB, XCVR_CLKBA, XCVR_SAB, XCVR_SBA = 0.
  - BUSY = 0, DONE = 0.
- IDLE:
  - XCVR_OE_n = 1, both strobes 0, both selects 0, XCVR_DIR holds its last value.
  - On REQ = 1, latch REQ_DIR and REQ_STORED.
  - If the latched direction differs from XCVR_DIR, go to TURN. Otherwise go to SETUP.
- TURN:
  - XCVR_DIR takes the new direction on entry; XCVR_OE_n = 1.
  - Lasts exactly TURN_CYCLES cycles, then go to SETUP.
- SETUP (1 cycle):
  - XCVR_OE_n = 1. The select line for the active direction takes REQ_STORED; the other select is 0.
  - If stored, go to CAPTURE. Otherwise go to DRIVE.
- CAPTURE (1 cycle):
  - The strobe for the source side is high: XCVR_CLKAB when DIR = 1, XCVR_CLKBA when DIR = 0.
  - XCVR_OE_n = 1. Go to DRIVE.
- DRIVE:
  - XCVR_OE_n = 0; selects are unchanged from SETUP.
  - A 4-bit counter runs DRIVE_CYCLES cycles.
  - After the last cycle, go to IDLE with DONE = 1 for that first IDLE cycle and XCVR_OE_n = 1.
- Back-to-back: REQ high during the DONE cycle is accepted; that cycle is IDLE.
- REQ outside IDLE is ignored and not queued.
- ABORT in any non-IDLE state:
  - Next cycle: IDLE, XCVR_OE_n = 1, strobes and selects 0, no DONE.
  - XCVR_DIR keeps its current value. If ABORT occurs in TURN, that value is the new direction.
  - ABORT in IDLE has no effect.
  - ABORT and REQ together in IDLE: REQ is accepted.
- RESET asserted mid-transfer: outputs go to their reset values immediately, with no DONE. The last-direction register returns to 0.

## Timing
- REQ is sampled at edge 0; the first state after IDLE begins at edge 1.
- Same direction, stored:
  - SETUP at cycle 1, CAPTURE at cycle 2, DRIVE at cycles 3 .. 2+DRIVE_CYCLES.
  - DONE at cycle 3+DRIVE_CYCLES.
- Same direction, real-time: DONE at cycle 2+DRIVE_CYCLES.
- A direction change adds TURN_CYCLES to either case.
- The strobe is high for exactly one cycle and always has XCVR_OE_n = 1 in the same cycle.
- XCVR_OE_n never goes low in the cycle in which XCVR_DIR or a select line changes.
- BUSY is high from cycle 1 through the last DRIVE cycle and low in the DONE cycle.

## Test plan
- Reset, then REQ = 1 with DIR = 0, STORED = 1, defaults:
  - Cycle 1: SBA = 1.
  - Cycle 2: CLKBA pulse.
  - Cycles 3–4: OE_n = 0.
  - Cycle 5: DONE; no TURN state.
- REQ with DIR = 1, STORED = 0 after a B to A transfer:
  - One TURN cycle with DIR = 1 and OE_n = 1.
  - SETUP with SAB = 0, then 2 DRIVE cycles.
  - DONE at cycle 5; no CLKAB pulse.
- REQ held high continuously, same direction, stored:
  - DONE at cycles 5, 10, 15.
  - OE_n high for 3 cycles between each drive window.
- ABORT in the first DRIVE cycle:
  - Next cycle OE_n = 1 and BUSY = 0, no DONE.
  - A new REQ then completes normally.
- RESET asserted asynchronously between edges in CAPTURE: strobe and selects drop at once, OE_n = 1, DIR = 0.
- DRIVE_CYCLES = 15, TURN_CYCLES = 7, direction change, stored: DONE exactly 25 cycles after REQ is sampled.
